// File: rtl/prach_reshape_pkg.sv
// Shared types and sizing helpers for the PRACH N-lane corner turn.
// Used by prach_reshape_nch and its sub-modules.
package prach_reshape_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int blk_w(input int lanes);
        return (lanes <= 2) ? 1 : $clog2(lanes);
    endfunction

    function automatic int idx_w(input int size);
        return $clog2(size) + 1;
    endfunction

    function automatic int lat(input int lanes, input int size);
        return (lanes - 1) * size + 1;
    endfunction

endpackage

// File: rtl/prach_delay.sv
// Plain shift-register delay line; DELAY=0 degenerates to a wire.
// Contents are deliberately not reset.
module prach_delay #(
    parameter int WIDTH = 16,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DELAY == 0) begin : g_wire
            logic w_unused_clk;
            assign w_unused_clk = clk;
            assign o_data       = i_data;
        end else begin : g_sr
            logic [WIDTH-1:0] r_sr [DELAY];
            always_ff @(posedge clk) begin
                r_sr[0] <= i_data;
                for (int i = 1; i < DELAY; i++)
                    r_sr[i] <= r_sr[i-1];
            end
            assign o_data = r_sr[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/prach_reshape_rot.sv
// Combinational lane rotator: out[l] = in[(amt - l) mod LANES],
// or out[l] = in[l] where the per-lane identity bit is set.
module prach_reshape_rot #(
    parameter int LANES = 2,
    parameter int WIDTH = 16,
    parameter int AW    = 1
) (
    input  logic [LANES*WIDTH-1:0] i_data,
    input  logic [AW-1:0]          i_amt,
    input  logic [LANES-1:0]       i_ident,
    output logic [LANES*WIDTH-1:0] o_data
);

    always_comb begin
        o_data = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < LANES; s++) begin
                if (i_ident[l] ? (s == l)
                               : (int'(i_amt) == (s + l) % LANES))
                    o_data[l*WIDTH +: WIDTH] = i_data[s*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/prach_reshape_nch.sv
// N-lane PRACH block transpose with run-time bypass and gap detection.
// Status counters are added when PRACH_RESHAPE_STATUS_EN is defined.
module prach_reshape_nch
    import prach_reshape_pkg::*;
#(
    parameter int LANES = 2,
    parameter int SIZE  = 8,
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*WIDTH-1:0]    din,
    input  logic                      din_dv,
    input  logic                      sync_in,
    input  logic                      cfg_bypass,
    output logic [LANES*WIDTH-1:0]    dout,
    output logic                      dout_dv,
    output logic [blk_w(LANES)-1:0]   dout_blk,
    output logic [idx_w(SIZE)-1:0]    dout_idx,
    output logic                      sync_out,
    output logic                      err_gap
`ifdef PRACH_RESHAPE_STATUS_EN
    ,
    output logic [15:0]               sts_frames,
    output logic [15:0]               sts_gaps
`endif
);

    localparam int BW  = blk_w(LANES);
    localparam int IW  = idx_w(SIZE);
    localparam int LAT = lat(LANES, SIZE);
    localparam int CW  = 2 + BW + IW;
    localparam logic [BW-1:0] BLK_LAST = BW'(LANES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(SIZE - 1);

    state_e            r_state;
    logic [BW-1:0]     r_blk;
    logic [IW-1:0]     r_idx;
    logic              r_err;
    logic [BW-1:0]     r_ph_blk;
    logic [IW-1:0]     r_ph_idx;
    logic              r_byp_cur;
    logic              r_byp_prev;
    logic [CW-1:0]     r_cpipe [LAT];
    logic [LANES*WIDTH-1:0] r_dout;

    logic              w_start;
    logic              w_cur_fin;
    logic [BW-1:0]     w_cur_blk, w_nxt_blk;
    logic [IW-1:0]     w_cur_idx, w_nxt_idx;
    logic [BW-1:0]     w_ph_blk, w_ph_nblk;
    logic [IW-1:0]     w_ph_idx, w_ph_nidx;
    logic              w_bnd;
    logic              w_byp_new, w_byp_old;
    logic [LANES-1:0]  w_ident;
    logic [BW-1:0]     w_ctl_blk;
    logic [IW-1:0]     w_ctl_idx;
    logic              w_frame_done;
    logic [LANES*WIDTH-1:0] w_pre, w_rot, w_post;

    always_comb begin
        w_start   = din_dv && (sync_in || r_state == IDLE);
        w_cur_blk = w_start ? '0 : r_blk;
        w_cur_idx = w_start ? '0 : r_idx;
        w_cur_fin = (w_cur_blk == BLK_LAST) && (w_cur_idx == IDX_LAST);
        w_nxt_idx = (w_cur_idx == IDX_LAST) ? '0 : w_cur_idx + IW'(1);
        w_nxt_blk = w_cur_blk;
        if (w_cur_idx == IDX_LAST)
            w_nxt_blk = (w_cur_blk == BLK_LAST) ? '0 : w_cur_blk + BW'(1);
        w_ctl_blk = din_dv ? w_cur_blk : '0;
        w_ctl_idx = din_dv ? w_cur_idx : '0;
    end

    // Free-running burst phase: keeps the tail of a frame rotating after
    // the input counters have returned to IDLE.
    always_comb begin
        w_ph_blk  = w_start ? '0 : r_ph_blk;
        w_ph_idx  = w_start ? '0 : r_ph_idx;
        w_bnd     = (w_ph_blk == '0) && (w_ph_idx == '0);
        w_ph_nidx = (w_ph_idx == IDX_LAST) ? '0 : w_ph_idx + IW'(1);
        w_ph_nblk = w_ph_blk;
        if (w_ph_idx == IDX_LAST)
            w_ph_nblk = (w_ph_blk == BLK_LAST) ? '0 : w_ph_blk + BW'(1);
        w_byp_new = w_start ? cfg_bypass : r_byp_cur;
        w_byp_old = w_bnd ? r_byp_cur : r_byp_prev;
        // Lanes above the phase still belong to the previous frame.
        for (int l = 0; l < LANES; l++)
            w_ident[l] = (BW'(l) <= w_ph_blk) ? w_byp_new : w_byp_old;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_blk   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (din_dv) begin
                        r_state <= w_cur_fin ? IDLE : RUN;
                        r_blk   <= w_nxt_blk;
                        r_idx   <= w_nxt_idx;
                    end
                end
                RUN: begin
                    if (!din_dv) begin
                        r_state <= IDLE;
                        r_blk   <= '0;
                        r_idx   <= '0;
                        r_err   <= 1'b1;
                    end else if (w_cur_fin) begin
                        r_state <= IDLE;
                        r_blk   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_blk   <= w_nxt_blk;
                        r_idx   <= w_nxt_idx;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph_blk   <= '0;
            r_ph_idx   <= '0;
            r_byp_cur  <= 1'b0;
            r_byp_prev <= 1'b0;
        end else begin
            r_ph_blk   <= w_ph_nblk;
            r_ph_idx   <= w_ph_nidx;
            r_byp_cur  <= w_byp_new;
            r_byp_prev <= w_byp_old;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++)
                r_cpipe[i] <= '0;
        end else begin
            r_cpipe[0] <= {din_dv, w_start, w_ctl_blk, w_ctl_idx};
            for (int i = 1; i < LAT; i++)
                r_cpipe[i] <= r_cpipe[i-1];
        end
    end

    assign {dout_dv, sync_out, dout_blk, dout_idx} = r_cpipe[LAT-1];
    assign err_gap = r_err;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            prach_delay #(
                .WIDTH (WIDTH),
                .DELAY (g * SIZE)
            ) u_pre (
                .clk    (clk),
                .i_data (din[g*WIDTH +: WIDTH]),
                .o_data (w_pre[g*WIDTH +: WIDTH])
            );
            prach_delay #(
                .WIDTH (WIDTH),
                .DELAY ((LANES - 1 - g) * SIZE)
            ) u_post (
                .clk    (clk),
                .i_data (w_rot[g*WIDTH +: WIDTH]),
                .o_data (w_post[g*WIDTH +: WIDTH])
            );
        end
    endgenerate

    prach_reshape_rot #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .AW    (BW)
    ) u_rot (
        .i_data  (w_pre),
        .i_amt   (w_ph_blk),
        .i_ident (w_ident),
        .o_data  (w_rot)
    );

    always_ff @(posedge clk)
        r_dout <= w_post;

    assign dout = r_dout;

    assign w_frame_done = dout_dv && (dout_blk == BLK_LAST)
                          && (dout_idx == IDX_LAST);

`ifdef PRACH_RESHAPE_STATUS_EN
    logic [15:0] r_frames;
    logic [15:0] r_gaps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frames <= '0;
            r_gaps   <= '0;
        end else begin
            if (w_frame_done)
                r_frames <= r_frames + 16'd1;
            if (r_err && r_gaps != 16'hFFFF)
                r_gaps <= r_gaps + 16'd1;
        end
    end

    assign sts_frames = r_frames;
    assign sts_gaps   = r_gaps;
`else
    logic w_unused_done;
    assign w_unused_done = w_frame_done;
`endif

endmodule

// File: tb/tb_prach_reshape_nch.sv
// Scoreboard bench for prach_reshape_nch at LANES=4, SIZE=2, WIDTH=16.
// Sample word = {burst[3:0], lane[3:0], idx[7:0]}.
module tb_prach_reshape_nch;

    localparam int LANES = 4;
    localparam int SIZE  = 2;
    localparam int WIDTH = 16;
    localparam int L     = 7;
    localparam int FR    = LANES * SIZE;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din;
    logic        din_dv;
    logic        sync_in;
    logic        cfg_bypass;
    logic [63:0] dout;
    logic        dout_dv;
    logic [1:0]  dout_blk;
    logic [1:0]  dout_idx;
    logic        sync_out;
    logic        err_gap;
`ifdef PRACH_RESHAPE_STATUS_EN
    logic [15:0] sts_frames;
    logic [15:0] sts_gaps;
`endif

    prach_reshape_nch #(
        .LANES (LANES),
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_dv     (din_dv),
        .sync_in    (sync_in),
        .cfg_bypass (cfg_bypass),
        .dout       (dout),
        .dout_dv    (dout_dv),
        .dout_blk   (dout_blk),
        .dout_idx   (dout_idx),
        .sync_out   (sync_out),
        .err_gap    (err_gap)
`ifdef PRACH_RESHAPE_STATUS_EN
        ,
        .sts_frames (sts_frames),
        .sts_gaps   (sts_gaps)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        bit          chk;
        logic [1:0]  blk;
        logic [1:0]  idx;
        logic        sync;
        int          at;
        int          lit_lane;
        logic [15:0] lit_val;
    } exp_t;

    exp_t q[$];
    int   err_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   exp_frames = 0;
    int   exp_gaps   = 0;

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        bit   w;
        if (dout_dv === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out cyc=%0d got dv=1 required none", cyc);
            end else begin
                e  = q.pop_front();
                ok = (cyc == e.at) && (dout_blk === e.blk) && (dout_idx === e.idx)
                     && (sync_out === e.sync) && (!e.chk || dout === e.data);
                if (!ok) begin
                    failures++;
                    $display("FAIL out cyc=%0d got blk=%0d idx=%0d sync=%b data=%h required cyc=%0d blk=%0d idx=%0d sync=%b data=%h chk=%0d",
                             cyc, dout_blk, dout_idx, sync_out, dout,
                             e.at, e.blk, e.idx, e.sync, e.data, e.chk);
                end
                if (e.lit_lane >= 0) begin
                    checks++;
                    if (dout[e.lit_lane*16 +: 16] !== e.lit_val) begin
                        failures++;
                        $display("FAIL literal lane%0d cyc=%0d got=%h required=%h",
                                 e.lit_lane, cyc, dout[e.lit_lane*16 +: 16], e.lit_val);
                    end
                end
            end
        end else if (q.size() > 0 && cyc >= q[0].at) begin
            checks++;
            failures++;
            e = q.pop_front();
            $display("FAIL missing_out cyc=%0d got dv=0 required blk=%0d idx=%0d",
                     cyc, e.blk, e.idx);
        end
        w = (err_q.size() > 0) && (err_q[0] == cyc);
        if (w || err_gap === 1'b1) begin
            checks++;
            if (err_gap !== w) begin
                failures++;
                $display("FAIL err_gap cyc=%0d got=%b required=%b", cyc, err_gap, w);
            end
            if (w) void'(err_q.pop_front());
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic idle(input int n);
        din_dv  = 1'b0;
        sync_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit byp, input bit use_sync, input int nsend,
                              input bit gap, input int lit_s, input int lit_lane,
                              input logic [15:0] lit_val);
        exp_t e;
        for (int s = 0; s < nsend; s++) begin
            int b;
            int i;
            b = s / SIZE;
            i = s % SIZE;
            din_dv     = 1'b1;
            sync_in    = (s == 0) && use_sync;
            cfg_bypass = (s == 0) ? byp : !byp;
            for (int l = 0; l < LANES; l++) begin
                din[l*16 +: 16] = {4'(b), 4'(l), 8'(i)};
                e.data[l*16 +: 16] = byp ? {4'(b), 4'(l), 8'(i)}
                                         : {4'(l), 4'(b), 8'(i)};
            end
            e.chk      = (nsend == FR);
            e.blk      = 2'(b);
            e.idx      = 2'(i);
            e.sync     = (s == 0);
            e.at       = cyc + L;
            e.lit_lane = (s == lit_s) ? lit_lane : -1;
            e.lit_val  = lit_val;
            q.push_back(e);
            @(posedge clk);
            #1;
        end
        din_dv  = 1'b0;
        sync_in = 1'b0;
        if (nsend == FR) exp_frames++;
        if (gap) begin
            err_q.push_back(cyc + 1);
            exp_gaps++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_dv     = 1'b0;
        sync_in    = 1'b0;
        cfg_bypass = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_dv",  64'(dout_dv),  64'd0);
        check("rst_sync_out", 64'(sync_out), 64'd0);
        check("rst_err_gap",  64'(err_gap),  64'd0);
        check("rst_dout_blk", 64'(dout_blk), 64'd0);
        check("rst_dout_idx", 64'(dout_idx), 64'd0);
        rst = 1'b0;
        idle(2);

        // single transposed frame: out lane1 burst2 idx1 = in burst1 lane2
        send_frame(1'b0, 1'b1, FR, 1'b0, 5, 1, 16'h1201);
        idle(10);

        // back-to-back: transpose then bypass, no gap
        send_frame(1'b0, 1'b1, FR, 1'b0, 3, 2, 16'h2101);
        send_frame(1'b1, 1'b0, FR, 1'b0, 3, 2, 16'h1201);
        idle(10);

        // gap on sample 3, next frame two cycles after the drop
        send_frame(1'b0, 1'b1, 3, 1'b1, -1, -1, 16'h0);
        idle(1);
        send_frame(1'b0, 1'b0, FR, 1'b0, -1, -1, 16'h0);
        idle(10);

        // second gap, in bypass
        send_frame(1'b1, 1'b1, 1, 1'b1, -1, -1, 16'h0);
        idle(3);

        // sync restart at sample 5
        send_frame(1'b0, 1'b1, 5, 1'b0, -1, -1, 16'h0);
        send_frame(1'b0, 1'b1, FR, 1'b0, -1, -1, 16'h0);
        idle(10);

`ifdef PRACH_RESHAPE_STATUS_EN
        check("sts_frames", 64'(sts_frames), 64'(exp_frames));
        check("sts_gaps",   64'(sts_gaps),   64'(exp_gaps));
`endif

        // reset while a frame is emerging and another is arriving
        send_frame(1'b0, 1'b1, FR, 1'b0, -1, -1, 16'h0);
        send_frame(1'b0, 1'b1, 3, 1'b0, -1, -1, 16'h0);
        rst = 1'b1;
        q.delete();
        err_q.delete();
        exp_frames = 0;
        exp_gaps   = 0;
        #1;
        check("midrst_dout_dv",  64'(dout_dv),  64'd0);
        check("midrst_sync_out", 64'(sync_out), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        send_frame(1'b1, 1'b1, FR, 1'b0, 3, 2, 16'h1201);
        idle(10);

`ifdef PRACH_RESHAPE_STATUS_EN
        check("sts_frames_rst", 64'(sts_frames), 64'(exp_frames));
        check("sts_gaps_rst",   64'(sts_gaps),   64'(exp_gaps));
`endif

        check("queue_drained", 64'(q.size()), 64'd0);
        check("err_drained",   64'(err_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
